ft245_sync_bus_arbiter: RTL and testbench

- Sequences the FT2232H FT245 synchronous FIFO bus and shares it between an RX sink (host→FPGA bytes) and a TX source (FPGA→host bytes).
- Owns oe_n/rd_n/wr_n and the FPGA-side data-bus output enable, including bus turnaround.
- Arbitrates RX vs TX round-robin with a per-grant burst limit.
- Sits between the FT2232H pins (clocked by its CLKOUT) and the LED/DAQ datapaths.

---
 rtl/ft245_sync_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ft245_sync_bus_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ft245_sync_bus_arbiter.sv
// FT2232H FT245 synchronous FIFO bus sequencer: shares the pins between an RX
// sink and a TX source with round-robin grants, burst limiting and turnaround.
module ft245_sync_bus_arbiter #(
   parameter int MAX_BURST = 64,
   parameter int BURST_W   = 7
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rxf_n_i,
   input  logic       txe_n_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       data_oe_o,
   output logic       oe_n_o,
   output logic       rd_n_o,
   output logic       wr_n_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_space_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       busy_o,
   output logic [2:0] dbg_state_o
);

   // tx_data_i/tx_valid_i -> tx_ready_o: a byte is taken on any rising edge
   // where tx_valid_i & tx_ready_o; the source holds data stable until then.
   typedef enum logic [2:0] {IDLE, RX_TURN, RX_RD, RX_END, TX_WR, TX_END} state_t;

   localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

   state_t             st_q, st_d;
   logic               oe_n_q, oe_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
   logic               doe_q, doe_d;
   logic [7:0]         dout_q, dout_d;
   logic [7:0]         rxd_q;
   logic               rxv_q;
   logic [7:0]         hold_q, hold_d;
   logic               full_q, full_d;
   logic               last_tx_q, last_tx_d;
   logic [BURST_W-1:0] burst_q, burst_d, burst_inc;
   logic               rd_xfer, wr_xfer, tx_take, rx_req, tx_req, rx_win;

   assign rd_xfer   = !rd_n_q && !rxf_n_i;
   assign wr_xfer   = !wr_n_q && !txe_n_i;
   assign tx_ready_o = !rst_i && (!full_q || wr_xfer);
   assign tx_take   = tx_valid_i && tx_ready_o;
   assign rx_req    = !rxf_n_i && rx_space_i;
   assign tx_req    = !txe_n_i && full_q;
   // On a tie, the side that did not hold the bus last wins.
   assign rx_win    = rx_req && (!tx_req || last_tx_q);
   assign burst_inc = ((rd_xfer || wr_xfer) && burst_q != MAX_B) ? burst_q + 1'b1 : burst_q;

   always_comb begin
      hold_d = hold_q;
      full_d = full_q;
      if (tx_take) begin
         hold_d = tx_data_i;
         full_d = 1'b1;
      end else if (wr_xfer) begin
         full_d = 1'b0;
      end
   end

   always_comb begin
      st_d      = st_q;
      oe_n_d    = 1'b1;
      rd_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      doe_d     = 1'b0;
      dout_d    = dout_q;
      burst_d   = burst_inc;
      last_tx_d = last_tx_q;
      case (st_q)
         IDLE: begin
            if (rx_win) begin
               st_d      = RX_TURN;
               oe_n_d    = 1'b0;
               burst_d   = '0;
               last_tx_d = 1'b0;
            end else if (tx_req) begin
               st_d      = TX_WR;
               doe_d     = 1'b1;
               wr_n_d    = 1'b0;
               dout_d    = hold_q;
               burst_d   = '0;
               last_tx_d = 1'b1;
            end
         end
         RX_TURN: begin
            st_d   = RX_RD;
            oe_n_d = 1'b0;
            rd_n_d = !(rx_req && burst_q < MAX_B);
         end
         RX_RD: begin
            if (rx_req && burst_inc < MAX_B) begin
               oe_n_d = 1'b0;
               rd_n_d = 1'b0;
            end else begin
               st_d = RX_END;
            end
         end
         TX_WR: begin
            // A byte refused with TXE# high stays in the hold register.
            if (!txe_n_i && full_d && burst_inc < MAX_B) begin
               doe_d  = 1'b1;
               wr_n_d = 1'b0;
               dout_d = hold_d;
            end else begin
               st_d = TX_END;
            end
         end
         RX_END:  st_d = IDLE;
         TX_END:  st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q      <= IDLE;
         oe_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         doe_q     <= 1'b0;
         dout_q    <= 8'h00;
         rxd_q     <= 8'h00;
         rxv_q     <= 1'b0;
         hold_q    <= 8'h00;
         full_q    <= 1'b0;
         last_tx_q <= 1'b1;
         burst_q   <= '0;
      end else begin
         st_q      <= st_d;
         oe_n_q    <= oe_n_d;
         rd_n_q    <= rd_n_d;
         wr_n_q    <= wr_n_d;
         doe_q     <= doe_d;
         dout_q    <= dout_d;
         rxv_q     <= rd_xfer;
         if (rd_xfer) rxd_q <= data_i;
         hold_q    <= hold_d;
         full_q    <= full_d;
         last_tx_q <= last_tx_d;
         burst_q   <= burst_d;
      end
   end

   assign data_o      = dout_q;
   assign data_oe_o   = doe_q;
   assign oe_n_o      = oe_n_q;
   assign rd_n_o      = rd_n_q;
   assign wr_n_o      = wr_n_q;
   assign rx_data_o   = rxd_q;
   assign rx_valid_o  = rxv_q;
   assign busy_o      = (st_q != IDLE);
   assign dbg_state_o = st_q;

endmodule

// File: tb/tb_ft245_sync_bus_arbiter.sv
// Directed bench for ft245_sync_bus_arbiter with MAX_BURST=4; simple FT host
// and TX source models advance their data on each completed transfer.
module tb_ft245_sync_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst, rxf_n, txe_n, rx_space, tx_valid;
   logic [7:0] din, tx_data;
   logic [7:0] data_o, rx_data;
   logic       data_oe, oe_n, rd_n, wr_n, rx_valid, tx_ready, busy;
   logic [2:0] dbg_state;

   int vectors = 0;
   int miscompares = 0;
   int host_left = 0;
   int src_left = 0;

   logic [7:0] rx_log[$];
   logic [7:0] wr_log[$];
   logic [7:0] exp_q[$];

   logic [3:0] t2 [0:11];
   logic [2:0] t3 [0:5];
   logic [2:0] t4 [0:8];
   logic [7:0] d4 [0:8];
   logic [3:0] t5 [0:20];
   logic [3:0] t6 [0:10];

   always #5 clk = ~clk;

   ft245_sync_bus_arbiter #(.MAX_BURST(4), .BURST_W(7)) dut (
      .clk_i(clk), .rst_i(rst), .rxf_n_i(rxf_n), .txe_n_i(txe_n), .data_i(din),
      .data_o(data_o), .data_oe_o(data_oe), .oe_n_o(oe_n), .rd_n_o(rd_n), .wr_n_o(wr_n),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_space_i(rx_space),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
      .busy_o(busy), .dbg_state_o(dbg_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, then step the host/source models.
   task automatic tick();
      logic rx_fire, tx_fire, wr_fire;
      @(negedge clk);
      rx_fire = !rd_n && !rxf_n;
      tx_fire = tx_valid && tx_ready;
      wr_fire = !wr_n && !txe_n;
      if (wr_fire === 1'b1) wr_log.push_back(data_o);
      if (rx_valid === 1'b1) rx_log.push_back(rx_data);
      @(posedge clk);
      #1;
      if (rx_fire === 1'b1 && host_left > 0) begin
         din = din + 8'd1;
         host_left--;
         if (host_left == 0) rxf_n = 1'b1;
      end
      if (tx_fire === 1'b1 && src_left > 0) begin
         tx_data = tx_data + 8'd1;
         src_left--;
         if (src_left == 0) tx_valid = 1'b0;
      end
      chk("inv_oe_doe", {31'd0, (!oe_n && data_oe)}, 32'd0);
      chk("inv_rd_wr", {31'd0, (!rd_n && !wr_n)}, 32'd0);
      chk("inv_rd_oe", {31'd0, (!rd_n && oe_n)}, 32'd0);
   endtask

   task automatic chk_log(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
      chk({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk(tag, {24'd0, got[i]}, {24'd0, exp[i]});
   endtask

   initial begin
      // {oe_n, rd_n, rx_valid, busy}
      t2 = '{4'b0101, 4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b1111,
             4'b1100, 4'b0101, 4'b0001, 4'b0011, 4'b1101, 4'b1100};
      // {wr_n, data_oe, busy}
      t3 = '{3'b100, 3'b011, 3'b011, 3'b011, 3'b101, 3'b100};
      t4 = '{3'b100, 3'b011, 3'b011, 3'b101, 3'b100, 3'b011, 3'b011, 3'b101, 3'b100};
      d4 = '{8'h00, 8'hA0, 8'hA1, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'h00, 8'h00};
      // {oe_n, rd_n, wr_n, data_oe}
      t5 = '{4'b0110, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1110, 4'b1110,
             4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1110, 4'b1110,
             4'b0110, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1110, 4'b1110, 4'b1101};
      // {oe_n, rd_n, rx_valid, busy}
      t6 = '{4'b0101, 4'b0001, 4'b0011, 4'b0011, 4'b1111, 4'b1100, 4'b1100,
             4'b1100, 4'b0101, 4'b0001, 4'b0011};

      // Reset held with host data pending and a source byte offered.
      rst = 1'b1; rxf_n = 1'b0; txe_n = 1'b1; rx_space = 1'b1;
      tx_valid = 1'b1; tx_data = 8'h55; din = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_pins", {25'd0, oe_n, rd_n, wr_n, data_oe, rx_valid, tx_ready, busy}, 32'b1110000);
         chk("rst_data", {16'd0, data_o, rx_data}, 32'd0);
      end
      rst = 1'b0; rxf_n = 1'b1; tx_valid = 1'b0;
      #1;
      chk("rel_tx_ready", {31'd0, tx_ready}, 32'd1);
      tick();
      chk("rel_idle", {29'd0, busy, oe_n, wr_n}, 32'b011);

      // Host sends 0x11..0x15; burst limit 4 splits it into 4 + 1.
      rx_log.delete(); din = 8'h11; host_left = 5; rxf_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("rx5_c%0d", i), {28'd0, oe_n, rd_n, rx_valid, busy}, {28'd0, t2[i]});
      end
      exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      chk_log("rx5_bytes", rx_log, exp_q);

      // Source offers 0xA0..0xA2 with TXE# low throughout.
      wr_log.delete(); tx_data = 8'hA0; src_left = 3; tx_valid = 1'b1; txe_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("tx3_c%0d", i), {29'd0, wr_n, data_oe, busy}, {29'd0, t3[i]});
         if (i >= 1 && i <= 3) chk($sformatf("tx3_d%0d", i), {24'd0, data_o}, {24'd0, 8'h9F + 8'(i)});
      end
      exp_q = '{8'hA0, 8'hA1, 8'hA2};
      chk_log("tx3_ft", wr_log, exp_q);

      // TXE# pulses high while 0xA1 is on the bus: it is resent in the next grant.
      wr_log.delete(); tx_data = 8'hA0; src_left = 3; tx_valid = 1'b1; txe_n = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("txe_c%0d", i), {29'd0, wr_n, data_oe, busy}, {29'd0, t4[i]});
         if (t4[i][2] == 1'b0) chk($sformatf("txe_d%0d", i), {24'd0, data_o}, {24'd0, d4[i]});
         if (i == 2) txe_n = 1'b1;
         if (i == 3) txe_n = 1'b0;
      end
      chk_log("txe_ft", wr_log, exp_q);

      // Both sides requesting continuously: RX,TX,RX,TX with 4 bytes each.
      rx_log.delete(); wr_log.delete();
      din = 8'h30; host_left = 100; rxf_n = 1'b0;
      tx_data = 8'hB0; src_left = 100; tx_valid = 1'b1; txe_n = 1'b0;
      for (int i = 0; i < 21; i++) begin
         tick();
         chk($sformatf("alt_c%0d", i), {28'd0, oe_n, rd_n, wr_n, data_oe}, {28'd0, t5[i]});
      end
      chk("alt_b4", {24'd0, data_o}, 32'hB4);
      exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
      chk_log("alt_rx", rx_log, exp_q);
      exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
      chk_log("alt_tx", wr_log, exp_q);

      // Reset mid-write: the held byte is dropped, nothing is retried.
      rst = 1'b1; host_left = 0; rxf_n = 1'b1; src_left = 0; tx_valid = 1'b0;
      tick();
      chk("mid_rst", {21'd0, busy, wr_n, data_oe, data_o}, {21'd0, 3'b010, 8'h00});
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("post_rst_idle", {29'd0, busy, wr_n, tx_ready}, 32'b011);
      end
      txe_n = 1'b1;

      // rx_space_i drops after byte 2: one more byte, then RX resumes later.
      rx_log.delete(); din = 8'h50; host_left = 10; rxf_n = 1'b0; rx_space = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick();
         chk($sformatf("spc_c%0d", i), {28'd0, oe_n, rd_n, rx_valid, busy}, {28'd0, t6[i]});
         if (i == 3) rx_space = 1'b0;
         if (i == 7) rx_space = 1'b1;
      end
      host_left = 0; rxf_n = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("spc_idle", {30'd0, busy, oe_n}, 32'b01);
      exp_q = '{8'h50, 8'h51, 8'h52, 8'h53};
      chk_log("spc_rx", rx_log, exp_q);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
